// File: rtl/fixed_point_divider_seq.sv
// Sequential restoring Q-format divider (unsigned/signed) with saturation and divide-by-zero flag.
// Latency WIDTH+FRAC+1 edges start-to-done (1 on divide-by-zero); start/loads ignored while running.
module fixed_point_divider_seq #(
  parameter int WIDTH = 10,
  parameter int FRAC  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sgn,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic             ov,
  output logic             dz
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] MAG_POS = {{(N-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [N-1:0] MAG_NEG = MAG_POS + 1'b1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, bmag_q;
  logic             sgn_q, neg_q, dzp_q;
  logic [N-1:0]     dvd_q, quo_q;
  logic [WIDTH:0]   rem_q;
  logic             busy_q, done_q, ov_q, dz_q;
  logic [WIDTH-1:0] q_q;

  logic [WIDTH-1:0] a_mag, b_mag, q_trunc, q_res, q_sat;
  logic [WIDTH:0]   rem_sh, rem_d;
  logic             qbit_d, ov_d, accept;

  assign busy = busy_q;
  assign done = done_q;
  assign Q    = q_q;
  assign ov   = ov_q;
  assign dz   = dz_q;

  assign accept = start && (state_q == IDLE || state_q == DONE);
  assign a_mag  = (sgn && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_mag  = (sgn && b_q[WIDTH-1]) ? -b_q : b_q;

  always_comb begin
    rem_sh = {rem_q[WIDTH-1:0], dvd_q[N-1]};
    rem_d  = rem_sh;
    qbit_d = 1'b0;
    if (rem_sh >= {1'b0, bmag_q}) begin
      rem_d  = rem_sh - {1'b0, bmag_q};
      qbit_d = 1'b1;
    end
  end

  // Signed negative results may reach one more than positive ones (the most-negative code).
  always_comb begin
    q_trunc = quo_q[WIDTH-1:0];
    q_res   = neg_q ? -q_trunc : q_trunc;
    if (!sgn_q)     ov_d = |quo_q[N-1:WIDTH];
    else if (neg_q) ov_d = (quo_q > MAG_NEG);
    else            ov_d = (quo_q > MAG_POS);
    if (!sgn_q)     q_sat = {WIDTH{1'b1}};
    else if (neg_q) q_sat = {1'b1, {(WIDTH-1){1'b0}}};
    else            q_sat = {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      bmag_q  <= '0;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      dzp_q   <= 1'b0;
      dvd_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ov_q    <= 1'b0;
      dz_q    <= 1'b0;
      q_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (ld_a) a_q <= A;
          if (ld_b) b_q <= B;
          state_q <= IDLE;
          if (accept) begin
            sgn_q   <= sgn;
            neg_q   <= sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            bmag_q  <= b_mag;
            dvd_q   <= {a_mag, {FRAC{1'b0}}};
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            dz_q    <= 1'b0;
            dzp_q   <= (b_q == '0);
            busy_q  <= (b_q != '0);
            state_q <= RUN;
          end
        end
        RUN: begin
          if (dzp_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            q_q     <= q_sat;
            ov_q    <= 1'b1;
            dz_q    <= 1'b1;
          end else if (cnt_q == CW'(N)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            q_q     <= ov_d ? q_sat : q_res;
            ov_q    <= ov_d;
          end else begin
            rem_q <= rem_d;
            quo_q <= {quo_q[N-2:0], qbit_d};
            dvd_q <= {dvd_q[N-2:0], 1'b0};
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_divider_seq.sv
// Directed bench for fixed_point_divider_seq (WIDTH=10, FRAC=5): vector table plus handshake/reset sequences.
module tb_fixed_point_divider_seq;

  logic       clk, rst, ld_a, ld_b, sgn, start;
  logic [9:0] A, B;
  logic       busy, done, ov, dz;
  logic [9:0] Q;

  int checks = 0;
  int errors = 0;

  fixed_point_divider_seq #(.WIDTH(10), .FRAC(5)) dut (
    .clk(clk), .rst(rst), .ld_a(ld_a), .ld_b(ld_b), .A(A), .B(B),
    .sgn(sgn), .start(start), .busy(busy), .done(done), .Q(Q), .ov(ov), .dz(dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       sg;
    logic [9:0] a;
    logic [9:0] b;
    logic [9:0] q;
    logic       ov;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops(input logic [9:0] a, input logic [9:0] b);
    ld_a = 1'b1; ld_b = 1'b1; A = a; B = b;
    tick();
    ld_a = 1'b0; ld_b = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int dcount;
    rst = 1'b0; ld_a = 1'b0; ld_b = 1'b0; sgn = 1'b0; start = 1'b0; A = '0; B = '0;

    //           sg    a        b        q         ov    dz    lat
    vecs[0]  = '{1'b0, 10'd96,  10'd48,  10'd64,   1'b0, 1'b0, 16};
    vecs[1]  = '{1'b0, 10'd32,  10'd96,  10'd10,   1'b0, 1'b0, 16};
    vecs[2]  = '{1'b0, 10'd1023,10'd1,   10'd1023, 1'b1, 1'b0, 16};
    vecs[3]  = '{1'b1, 10'd511, 10'd1,   10'd511,  1'b1, 1'b0, 16};
    vecs[4]  = '{1'b1, 10'd928, 10'd48,  10'd960,  1'b0, 1'b0, 16};
    vecs[5]  = '{1'b1, 10'd928, 10'd976, 10'd64,   1'b0, 1'b0, 16};
    vecs[6]  = '{1'b0, 10'd96,  10'd0,   10'd1023, 1'b1, 1'b1, 1};
    vecs[7]  = '{1'b0, 10'd96,  10'd48,  10'd64,   1'b0, 1'b0, 16};
    vecs[8]  = '{1'b1, 10'd512, 10'd32,  10'd512,  1'b0, 1'b0, 16};
    vecs[9]  = '{1'b1, 10'd512, 10'd992, 10'd511,  1'b1, 1'b0, 16};
    vecs[10] = '{1'b1, 10'd512, 10'd1,   10'd512,  1'b1, 1'b0, 16};
    vecs[11] = '{1'b1, 10'd928, 10'd0,   10'd512,  1'b1, 1'b1, 1};
    vecs[12] = '{1'b0, 10'd1,   10'd1023,10'd0,    1'b0, 1'b0, 16};
    vecs[13] = '{1'b0, 10'd480, 10'd64,  10'd240,  1'b0, 1'b0, 16};

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", Q, 0);
    chk("rst_ov", ov, 0);
    chk("rst_dz", dz, 0);
    tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      load_ops(vecs[i].a, vecs[i].b);
      sgn = vecs[i].sg;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk($sformatf("v%0d_busy", i), busy, vecs[i].dz ? 0 : 1);
      wait_done(lat);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_q", i), Q, vecs[i].q);
      chk($sformatf("v%0d_ov", i), ov, vecs[i].ov);
      chk($sformatf("v%0d_dz", i), dz, vecs[i].dz);
    end

    // Q is held through IDLE
    tick(); tick(); tick();
    chk("hold_q", Q, 240);
    chk("hold_done", done, 0);

    // Asynchronous reset mid-RUN
    load_ops(10'd96, 10'd48);
    sgn = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_q", Q, 0);
    chk("arst_ov", ov, 0);
    chk("arst_dz", dz, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    dcount = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done) dcount++;
    end
    chk("arst_no_done", dcount, 0);
    chk("arst_busy_after", busy, 0);

    // start/ld_a/ld_b during RUN are ignored
    load_ops(10'd96, 10'd48);
    sgn = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    ld_a = 1'b1; ld_b = 1'b1; A = 10'd32; B = 10'd96; start = 1'b1;
    tick();
    ld_a = 1'b0; ld_b = 1'b0; start = 1'b0;
    wait_done(lat);
    chk("ign_lat", lat, 12);
    chk("ign_q", Q, 64);

    // start during DONE, no load: operands must still be 96/48
    chk("dn1_done", done, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("dn1_busy", busy, 1);
    chk("dn1_done_fell", done, 0);
    wait_done(lat);
    chk("dn1_lat", lat, 16);
    chk("dn1_q", Q, 64);

    // load + start in DONE: start uses old operands, load takes effect afterwards
    ld_a = 1'b1; ld_b = 1'b1; A = 10'd32; B = 10'd96; start = 1'b1;
    tick();
    ld_a = 1'b0; ld_b = 1'b0; start = 1'b0;
    chk("dn2_busy", busy, 1);
    wait_done(lat);
    chk("dn2_lat", lat, 16);
    chk("dn2_q", Q, 64);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat);
    chk("dn3_lat", lat, 16);
    chk("dn3_q", Q, 10);
    chk("dn3_ov", ov, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
